fifo_buffer_param: RTL and testbench
====================================

// Module: fifo_buffer_param
// PURPOSE
//   Parametrised synchronous single-clock FIFO; successor to the fixed-depth buffer.
//   Holds exactly DEPTH entries (full = DEPTH stored, not DEPTH-1).
//   Adds occupancy count, programmable almost-full/almost-empty, read-valid strobe and
//   sticky overflow/underflow error flags. Sits between producer/consumer datapath stages.
// PARAMETERS
//   WIDTH    8   data word width in bits (>=1)
//   DEPTH   32   number of entries; power of two, >=2
//   AF_LVL  28   almost_full asserts when count >= AF_LVL (1..DEPTH)
//   AE_LVL   4   almost_empty asserts when count <= AE_LVL (0..DEPTH-1)
// PORTS
//   clk           in   1               clock, rising edge
//   rst           in   1               asynchronous reset, active-low (0 = reset)
//   wr_en         in   1               write request
//   wr_data       in   WIDTH           write data
//   rd_en         in   1               read/pop request
//   clr_err       in   1               clears overflow/underflow
//   rd_data       out  WIDTH           read data
//   rd_valid      out  1               rd_data holds a popped word (see BEHAVIOUR)
//   full          out  1               count == DEPTH
//   empty         out  1               count == 0
//   almost_full   out  1               count >= AF_LVL
//   almost_empty  out  1               count <= AE_LVL
//   count         out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//   overflow      out  1               sticky: write attempted while full
//   underflow     out  1               sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (rst=0, async assert, sync deassert by system): pointers=0, count=0, rd_data=0,
//     rd_valid=0, overflow=0, underflow=0 -> empty=1, full=0, almost_empty=1, almost_full=0.
//     Memory contents not reset. Reset mid-operation discards all stored data.
//   - Pointers $clog2(DEPTH)+1 bits; low bits address memory, wrap DEPTH-1 -> 0 naturally.
//   - Write accepted iff wr_en & !full (flags as registered before edge); rejected write
//     sets overflow, data dropped, FIFO unchanged.
//   - Read accepted iff rd_en & !empty; rejected read sets underflow, rd_valid=0.
//   - Simultaneous accepted write+read: count unchanged, both pointers advance.
//   - Full + wr_en + rd_en: read accepted, write rejected (overflow=1), count -> DEPTH-1.
//   - Empty + wr_en + rd_en: write accepted, read rejected (underflow=1), count -> 1.
//   - Flags full/empty/almost_* are registered/derived from count; valid 1 cycle after edge.
//   - clr_err=1 clears both sticky flags; error in same cycle wins (flag stays 1).
// CONFIGURATION
//   FIFO_FWFT_EN undefined (default): registered read, latency 1 -- word popped at edge N
//     appears on rd_data with rd_valid=1 after edge N; rd_valid is a 1-cycle pulse per pop;
//     rd_data holds last value otherwise.
//   FIFO_FWFT_EN defined: first-word fall-through -- rd_data = head word combinationally,
//     rd_valid = !empty; rd_en pops head (acknowledge). Write to empty FIFO visible on
//     rd_data the cycle after the write edge. Full/empty/error rules unchanged.
// STRUCTURE
//   - Package fifo_pkg: function ptr_w(depth) = $clog2(depth)+1; localparam checks
//     (DEPTH power of two, AF_LVL/AE_LVL ranges) as elaboration-time assertions.
//   - One sub-module: fifo_mem_dp -- WIDTH x DEPTH simple dual-port RAM, sync write,
//     async read port (registered externally in non-FWFT mode).
//   - Top holds pointer/count/flag logic and output register.
// TESTING (WIDTH=8, DEPTH=4, AF_LVL=3, AE_LVL=1; run with and without FIFO_FWFT_EN)
//   1 reset: rst=0 mid-stream with 3 words stored -> count=0, empty=1, rd_valid=0, errors=0.
//   2 fill: write 0xA0..0xA3 -> count 1,2,3,4; almost_full at 3; full at 4; almost_empty off at 2.
//   3 overflow: full, write 0xFF -> dropped, overflow=1, count=4; drain reads 0xA0..0xA3 in order.
//   4 wrap: 10 write/read pairs 0x00..0x09 at count=2 -> count stays 2, data order intact.
//   5 edges: full + wr+rd -> rd gives head, overflow=1, count=3; empty + wr+rd -> underflow=1,
//     count=1.
//   6 clr_err with no new error -> flags 0 next cycle; clr_err same cycle as underflow -> stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer width and elaboration-time
// parameter legality checks.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 32'sd2) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit levels_ok(input int depth, input int af_lvl, input int ae_lvl);
    return (af_lvl >= 32'sd1) && (af_lvl <= depth) &&
           (ae_lvl >= 32'sd0) && (ae_lvl <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// WIDTH x DEPTH simple dual-port storage: synchronous write port, asynchronous
// read port. Contents are intentionally not reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky
// errors. Define FIFO_FWFT_EN for first-word fall-through read behaviour.
module fifo_buffer_param
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int AF_LVL = 28,
  parameter int AE_LVL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] C_ONE   = PW'(1);
  localparam logic [PW-1:0] C_ZERO  = PW'(0);
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] C_AF    = PW'(AF_LVL);
  localparam logic [PW-1:0] C_AE    = PW'(AE_LVL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_buffer_param: DEPTH must be a power of two >= 2");
  end
  if (!levels_ok(DEPTH, AF_LVL, AE_LVL)) begin : g_bad_levels
    $error("fifo_buffer_param: AF_LVL/AE_LVL out of range");
  end

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_udf;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_mem_rdata;

  // Accept decisions use the flags registered before this edge
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  // Next occupancy from accepted operations
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= C_ZERO;
      r_rd_ptr <= C_ZERO;
      r_count  <= C_ZERO;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + C_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == C_ZERO);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (rd_en && r_empty) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; masked while empty so stale RAM never shows
  assign rd_data  = r_empty ? '0 : w_mem_rdata;
  assign rd_valid = ~r_empty;
`else
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Registered read port: one-cycle valid pulse per pop, data held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_mem_rdata;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Self-checking bench for fifo_buffer_param (WIDTH=8, DEPTH=4, AF=3, AE=1);
// honours FIFO_FWFT_EN when the design is built with it.
module tb_fifo_buffer_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t tbl[11];

  fifo_buffer_param #(
    .WIDTH (8),
    .DEPTH (4),
    .AF_LVL(3),
    .AE_LVL(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = sb.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == 4));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= 3));
    check("almost_empty", 32'(almost_empty), 32'(n <= 1));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic       pre_full;
    logic       pre_empty;
    logic       racc;
    logic [7:0] exp_d;
    @(negedge clk);
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    pre_full  = (sb.size() == 4);
    pre_empty = (sb.size() == 0);
    racc      = rd && !pre_empty;
    exp_d     = 8'h00;
`ifdef FIFO_FWFT_EN
    #1;
    check("fwft_valid", 32'(rd_valid), 32'(!pre_empty));
    if (racc) check("fwft_head", 32'(rd_data), 32'(sb[0]));
`endif
    if (racc) exp_d = sb.pop_front();
    if (wr && !pre_full) sb.push_back(d);
    if (wr && pre_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (rd && pre_empty) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;
    @(posedge clk);
    #1;
    check_state();
`ifndef FIFO_FWFT_EN
    check("rd_valid", 32'(rd_valid), 32'(racc));
    if (racc) check("rd_data", 32'(rd_data), 32'(exp_d));
`endif
  endtask

  initial begin
    // fill, overflow, drain, clear: {wr, data, rd, clr, count, ovf, udf}
    tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 4, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 4, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_state();
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-stream with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state();
    check("midreset_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table: fill, overflow, ordered drain, error clear
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr);
      check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      check("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
      check("tbl_underflow", 32'(underflow), 32'(tbl[i].exp_udf));
    end

    // Pointer wrap: simultaneous write/read pairs at count 2
    step(1'b1, 8'hB0, 1'b0, 1'b0);
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check("wrap_count", 32'(count), 32'd2);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with write+read: read wins, write dropped
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("edge_full_count", 32'(count), 32'd3);
    check("edge_full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with write+read: write wins, read rejected
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("edge_empty_count", 32'(count), 32'd1);
    check("edge_empty_udf", 32'(underflow), 32'd1);

    // Clear without new error, then clear colliding with underflow
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_udf", 32'(underflow), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("clr_collide_udf", 32'(underflow), 32'd1);

    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
